// File: rtl/functs.sv
// rtl/functs.sv - shared fixed-point helpers and default datapath constants
package functs;

    localparam int FRAC_BITS_Q10 = 10;
    localparam int DATA_WIDTH_32 = 32;
    localparam int MAX_WIDTH     = 64;

    typedef struct packed {
        logic                 ovf;
        logic [MAX_WIDTH-1:0] data;
    } rescale_t;

    // Rescales a sign-extended product by frac_bits. Callers keep the low data_width bits of .data.
    function automatic rescale_t mul_frac_round_sat(
        input logic signed [2*MAX_WIDTH-1:0] product,
        input int                            data_width,
        input int                            frac_bits,
        input logic                          round_en,
        input logic                          sat_en
    );
        logic signed [2*MAX_WIDTH-1:0] one_wide;
        logic signed [2*MAX_WIDTH-1:0] rounded;
        logic signed [2*MAX_WIDTH-1:0] shifted;
        logic signed [2*MAX_WIDTH-1:0] hi_bound;
        logic signed [2*MAX_WIDTH-1:0] lo_bound;
        rescale_t                      res;
        one_wide = 1;
        rounded  = round_en ? product + (one_wide <<< (frac_bits - 1)) : product;
        shifted  = rounded >>> frac_bits;
        hi_bound = (one_wide <<< (data_width - 1)) - one_wide;
        lo_bound = -(one_wide <<< (data_width - 1));
        res.ovf  = (shifted > hi_bound) || (shifted < lo_bound);
        if (res.ovf && sat_en) begin
            res.data = (shifted < 0) ? lo_bound[MAX_WIDTH-1:0] : hi_bound[MAX_WIDTH-1:0];
        end else begin
            res.data = shifted[MAX_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - first-word-fall-through FIFO, pointers compared directly (clocks tied together)
module fifo #(
    parameter int FIFO_BUFFER_SIZE = 256,
    parameter int FIFO_DATA_WIDTH  = 32
) (
    input  logic                       wr_clk,
    input  logic                       rd_clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] din,
    output logic                       full,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] dout,
    output logic                       empty
);
    localparam int AW = $clog2(FIFO_BUFFER_SIZE);

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
    logic [AW:0]                wr_ptr;
    logic [AW:0]                rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Head reads as zero while empty so stale storage never shows on the output.
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (wr_en && !full) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_en && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/mul_frac_pipe_fifo.sv
// rtl/mul_frac_pipe_fifo.sv - pipelined signed fixed-point multiplier with credit-gated output FIFO
module mul_frac_pipe_fifo
    import functs::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_32,
    parameter int FRAC_BITS  = FRAC_BITS_Q10,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ina,
    input  logic [DATA_WIDTH-1:0] inb,
    input  logic                  ina_empty,
    input  logic                  inb_empty,
    output logic                  ina_rd_en,
    output logic                  inb_rd_en,
    input  logic                  round_en,
    input  logic                  sat_en,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_empty,
    input  logic                  out_rd_en,
    output logic                  overflow,
    input  logic                  clear_ovf,
    output logic                  busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]                 occ;
    logic [1:0]                    inflight;
    logic [CW:0]                   committed;
    logic                          issue;
    logic                          pop;
    logic                          fifo_full_unused;

    logic                          s1_valid, s2_valid, s3_valid;
    logic signed [DATA_WIDTH-1:0]  s1_a, s1_b;
    logic                          s1_round, s1_sat, s2_round, s2_sat;
    logic signed [2*DATA_WIDTH-1:0] s2_prod;
    logic [DATA_WIDTH-1:0]         s3_data;
    rescale_t                      rescale;

    // Every valid stage already owns a FIFO slot, so issue only while a free slot remains.
    assign inflight  = 2'(s1_valid) + 2'(s2_valid) + 2'(s3_valid);
    assign committed = (CW+1)'(occ) + (CW+1)'(inflight);
    assign issue     = !reset && !ina_empty && !inb_empty && (committed < (CW+1)'(FIFO_DEPTH));
    assign ina_rd_en = issue;
    assign inb_rd_en = issue;
    assign pop       = out_rd_en && !out_empty;
    assign busy      = s1_valid || s2_valid || s3_valid || !out_empty;

    always_comb begin
        rescale = mul_frac_round_sat((2*MAX_WIDTH)'(s2_prod), DATA_WIDTH, FRAC_BITS,
                                     s2_round, s2_sat);
    end

    generate
        if (DATA_WIDTH < MAX_WIDTH) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^rescale.data[MAX_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= issue;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (issue) begin
            s1_a     <= ina;
            s1_b     <= inb;
            s1_round <= round_en;
            s1_sat   <= sat_en;
        end
        s2_prod  <= (2*DATA_WIDTH)'(s1_a) * (2*DATA_WIDTH)'(s1_b);
        s2_round <= s1_round;
        s2_sat   <= s1_sat;
        s3_data  <= rescale.data[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (s2_valid && rescale.ovf) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ <= '0;
        end else begin
            case ({s3_valid, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    fifo #(
        .FIFO_BUFFER_SIZE (FIFO_DEPTH),
        .FIFO_DATA_WIDTH  (DATA_WIDTH)
    ) u_fifo (
        .wr_clk (clock),
        .rd_clk (clock),
        .reset  (reset),
        .wr_en  (s3_valid),
        .din    (s3_data),
        .full   (fifo_full_unused),
        .rd_en  (pop),
        .dout   (out),
        .empty  (out_empty)
    );

endmodule

// File: tb/tb_mul_frac_pipe_fifo.sv
// tb/tb_mul_frac_pipe_fifo.sv - scoreboard bench for mul_frac_pipe_fifo (depth 256 and depth 4 instances)
module tb_mul_frac_pipe_fifo;

    typedef struct {
        logic [31:0] a;
        logic        rnd;
        logic        sat;
    } a_entry_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, sel, out_rd, clear_ovf;
    logic [31:0] src_a, src_b;
    logic        src_a_empty, src_b_empty, round_en, sat_en;
    a_entry_t    qa[$];
    logic [31:0] qb[$];
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    logic        rd0a, rd0b, oe0, ovf0, busy0;
    logic        rd1a, rd1b, oe1, ovf1, busy1;
    logic [31:0] out0, out1;
    logic        rd_a, rd_b, oe, ovf, busy;
    logic [31:0] dout;

    assign rd_a = sel ? rd1a : rd0a;
    assign rd_b = sel ? rd1b : rd0b;
    assign oe   = sel ? oe1 : oe0;
    assign ovf  = sel ? ovf1 : ovf0;
    assign busy = sel ? busy1 : busy0;
    assign dout = sel ? out1 : out0;

    mul_frac_pipe_fifo dut (
        .clock(clock), .reset(reset),
        .ina(src_a), .inb(src_b),
        .ina_empty(sel | src_a_empty), .inb_empty(sel | src_b_empty),
        .ina_rd_en(rd0a), .inb_rd_en(rd0b),
        .round_en(round_en), .sat_en(sat_en),
        .out(out0), .out_empty(oe0), .out_rd_en(out_rd & ~sel),
        .overflow(ovf0), .clear_ovf(clear_ovf), .busy(busy0)
    );

    mul_frac_pipe_fifo #(.FIFO_DEPTH(4)) dut4 (
        .clock(clock), .reset(reset),
        .ina(src_a), .inb(src_b),
        .ina_empty(~sel | src_a_empty), .inb_empty(~sel | src_b_empty),
        .ina_rd_en(rd1a), .inb_rd_en(rd1b),
        .round_en(round_en), .sat_en(sat_en),
        .out(out1), .out_empty(oe1), .out_rd_en(out_rd & sel),
        .overflow(ovf1), .clear_ovf(clear_ovf), .busy(busy1)
    );

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic rnd, input logic sat);
        longint      p, s;
        logic        o;
        logic [31:0] r;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rnd) p = p + 64'sd512;
        s = p >>> 10;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r = s[31:0];
        if (o && sat) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {o, r};
    endfunction

    task automatic refresh();
        src_a_empty = (qa.size() == 0);
        src_b_empty = (qb.size() == 0);
        if (qa.size() != 0) begin
            src_a    = qa[0].a;
            round_en = qa[0].rnd;
            sat_en   = qa[0].sat;
        end else begin
            src_a    = '0;
            round_en = 1'b0;
            sat_en   = 1'b0;
        end
        src_b = (qb.size() != 0) ? qb[0] : '0;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic rnd, input logic sat);
        logic [32:0] m;
        a_entry_t    e;
        m = model(a, b, rnd, sat);
        e.a = a; e.rnd = rnd; e.sat = sat;
        qa.push_back(e);
        qb.push_back(b);
        exp_q.push_back(m[31:0]);
        refresh();
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Source FIFO model: pops follow the strobes seen in the cycle just ended.
    logic pa = 1'b0, pb = 1'b0;
    always @(negedge clock) begin
        pa = rd_a;
        pb = rd_b;
    end
    always @(posedge clock) begin
        #1;
        if (pa && qa.size() != 0) qa.delete(0);
        if (pb && qb.size() != 0) qb.delete(0);
        refresh();
    end

    // Output scoreboard.
    always @(negedge clock) begin
        if (!reset && out_rd && !oe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got %h with nothing expected", dout);
            end else begin
                if (dout !== exp_q[0]) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %h expected %h", dout, exp_q[0]);
                end
                exp_q.delete(0);
            end
        end
    end

    task automatic drain(input string name);
        out_rd = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (oe !== 1'b1)   begin errors++; $display("FAIL reset_out_empty: got %b expected 1", oe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (dout !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", dout); end
        if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
        if (rd_a !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_a); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        out_rd = 1'b0;
        push_pair(32'd2048, 32'd1536, 1'b0, 1'b0);
        repeat (3) tick();
        checks++;
        if (oe !== 1'b1) begin errors++; $display("FAIL latency_early: out_empty %b expected 1 at t+3", oe); end
        tick();
        checks += 2;
        if (oe !== 1'b0) begin errors++; $display("FAIL latency_t4: out_empty %b expected 0 at t+4", oe); end
        if (dout !== 32'd3072) begin errors++; $display("FAIL latency_value: got %h expected %h", dout, 32'd3072); end
        drain("latency");
    endtask

    task automatic test_rounding();
        push_pair(32'd1, 32'd512, 1'b0, 1'b0);
        push_pair(32'd1, 32'd512, 1'b1, 1'b0);
        push_pair(32'hFFFF_FFFF, 32'd512, 1'b0, 1'b0);
        push_pair(32'hFFFF_FFFF, 32'd512, 1'b1, 1'b0);
        drain("rounding");
    endtask

    task automatic test_back_to_back();
        int run, best, total;
        out_rd = 1'b1;
        for (int i = 0; i < 8; i++) push_pair(32'(i * 1000 - 3000), 32'(i * 77 + 5), i[0], 1'b0);
        run = 0; best = 0; total = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            if (rd_a) begin run++; total++; if (run > best) best = run; end else run = 0;
        end
        tick();
        checks += 2;
        if (best != 8)  begin errors++; $display("FAIL b2b_run: got %0d consecutive expected 8", best); end
        if (total != 8) begin errors++; $display("FAIL b2b_total: got %0d pops expected 8", total); end
        drain("b2b");
    endtask

    task automatic test_overflow();
        push_pair(32'h7FFF_FFFF, 32'd2048, 1'b0, 1'b1);
        drain("ovf_sat");
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag: got %b expected 1", ovf); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        push_pair(32'h7FFF_FFFF, 32'd2048, 1'b0, 1'b0);
        push_pair(32'h8000_0000, 32'd2048, 1'b0, 1'b1);
        push_pair(32'h8000_0000, 32'd2048, 1'b0, 1'b0);
        drain("ovf_wrap");
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag: got %b expected 1", ovf); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = (i % 3 == 0) ? $urandom : 32'($signed(17'($urandom)));
            b = (i % 4 == 0) ? $urandom : 32'($signed(15'($urandom)));
            push_pair(a, b, 1'($urandom), 1'($urandom));
        end
        for (int c = 0; c < 60; c++) begin
            out_rd = 1'($urandom);
            tick();
        end
        drain("random");
    endtask

    task automatic test_full_depth4();
        int pops;
        sel = 1'b1;
        out_rd = 1'b0;
        refresh();
        for (int i = 0; i < 10; i++) push_pair(32'(i * 4096 + 1024), 32'(3 - i) * 32'd1024, 1'b0, 1'b0);
        pops = 0;
        for (int c = 0; c < 20; c++) begin @(negedge clock); if (rd_a) pops++; end
        tick();
        checks += 2;
        if (pops != 4) begin errors++; $display("FAIL full_pops: got %0d expected 4", pops); end
        if (qa.size() != 6) begin errors++; $display("FAIL full_left: got %0d expected 6", qa.size()); end
        out_rd = 1'b1;
        tick();
        out_rd = 1'b0;
        pops = 0;
        for (int c = 0; c < 15; c++) begin @(negedge clock); if (rd_a) pops++; end
        tick();
        checks++;
        if (pops != 1) begin errors++; $display("FAIL full_one_more: got %0d expected 1", pops); end
        drain("full");
        checks++;
        if (qa.size() != 0) begin errors++; $display("FAIL full_sources: %0d left expected 0", qa.size()); end
        out_rd = 1'b0;
        tick();
        sel = 1'b0;
        refresh();
        tick();
    endtask

    task automatic test_one_empty();
        logic [31:0] bs[4];
        logic [32:0] m;
        a_entry_t    e;
        int          pops;
        out_rd = 1'b1;
        for (int i = 0; i < 4; i++) begin bs[i] = 32'(i * 2048 + 512); qb.push_back(bs[i]); end
        refresh();
        pops = 0;
        for (int c = 0; c < 20; c++) begin @(negedge clock); if (rd_b) pops++; end
        tick();
        checks += 2;
        if (pops != 0) begin errors++; $display("FAIL one_empty_pops: got %0d expected 0", pops); end
        if (qb.size() != 4) begin errors++; $display("FAIL one_empty_keep: got %0d expected 4", qb.size()); end
        for (int i = 0; i < 4; i++) begin
            e.a = 32'(i + 1) * 32'd1024; e.rnd = 1'b0; e.sat = 1'b0;
            m = model(e.a, bs[i], 1'b0, 1'b0);
            qa.push_back(e);
            exp_q.push_back(m[31:0]);
        end
        refresh();
        drain("one_empty");
    endtask

    task automatic test_reset_mid();
        out_rd = 1'b0;
        push_pair(32'd100, 32'd200, 1'b0, 1'b0);
        push_pair(32'd300, 32'd400, 1'b0, 1'b0);
        push_pair(32'd500, 32'd600, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        push_pair(32'd7168, 32'd3072, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (rd_a !== 1'b0) begin errors++; $display("FAIL rst_mid_pop: got %b expected 0", rd_a); end
        tick();
        reset = 1'b0;
        checks += 2;
        if (oe !== 1'b1)   begin errors++; $display("FAIL rst_mid_empty: got %b expected 1", oe); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        repeat (3) tick();
        checks++;
        if (oe !== 1'b1) begin errors++; $display("FAIL rst_mid_stray: out_empty %b expected 1", oe); end
        drain("rst_mid");
        repeat (4) tick();
        checks++;
        if (oe !== 1'b1) begin errors++; $display("FAIL rst_mid_tail: out_empty %b expected 1", oe); end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; out_rd = 1'b0; clear_ovf = 1'b0;
        refresh();
        test_reset();
        test_latency();
        test_rounding();
        test_back_to_back();
        test_overflow();
        test_random();
        test_full_depth4();
        test_one_empty();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mul_frac_pipe_fifo.md
# mul_frac_pipe_fifo

Parametrised, fully pipelined signed fixed-point multiplier for the FM datapath. It pops one operand pair per cycle from two first-word-fall-through input FIFOs, multiplies them, rescales by `FRAC_BITS` with selectable rounding and saturation, and writes the result into an internal output FIFO. Credit-based issue guarantees that no result is ever dropped. It replaces the fixed 32-bit/Q10, one-result-per-two-cycles multiplier stages in the demod and filter chains.

## Interface
- `DATA_WIDTH`, 32: operand and result width, two's complement.
- `FRAC_BITS`, 10: fractional bits of operands and result; must satisfy 1 ≤ `FRAC_BITS` < `DATA_WIDTH`.
- `FIFO_DEPTH`, 256: output FIFO depth; must be a power of two and ≥ 4.
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `ina` / `inb`  in  DATA_WIDTH  operands, valid whenever the matching `*_empty` is 0.
- `ina_empty` / `inb_empty`  in  1  source FIFO empty flags.
- `ina_rd_en` / `inb_rd_en`  out  1  pop strobes; always asserted together.
- `round_en`  in  1  1 = round half-up, 0 = truncate toward −∞; sampled at issue.
- `sat_en`  in  1  1 = saturate on overflow, 0 = wrap; sampled at issue.
- `out`  out  DATA_WIDTH  output FIFO head (FWFT).
- `out_empty`  out  1  output FIFO empty.
- `out_rd_en`  in  1  output pop; ignored while `out_empty` = 1.
- `overflow`  out  1  sticky: set when any result exceeded range, in either mode.
- `clear_ovf`  in  1  clears `overflow`; a set in the same cycle wins.
- `busy`  out  1  pipeline holds valid data, or the output FIFO is not empty.

## Operation
- Issue condition: `!ina_empty && !inb_empty && (occ + inflight) < FIFO_DEPTH`.
  - `occ` is the output FIFO occupancy counter.
  - `inflight` is the count of valid pipeline stages (0–3).
  - When the condition holds, both rd_en strobes are asserted in that cycle. `ina`, `inb`, `round_en` and `sat_en` are captured into S1.
- S1→S2: full signed product, 2·DATA_WIDTH bits.
- S2→S3: rescale and range check.
  - If `round_en`, add 2^(FRAC_BITS−1) to the product.
  - Arithmetic right shift by `FRAC_BITS`.
  - Overflow = shifted value outside [−2^(W−1), 2^(W−1)−1].
  - `sat_en` clamps to the nearest bound; otherwise the result keeps the low W bits.
  - An overflow sets `overflow`.
- S3: registered write into the output FIFO, unconditional. Credits guarantee space.
- The pipeline never stalls. Each stage carries a valid bit, and bubbles propagate.
- `occ`: +1 on write, −1 on effective pop, unchanged when both happen in the same cycle.
- Reset:
  - Clears all valid bits, `occ`, `overflow` and the FIFO.
  - `ina_rd_en` = `inb_rd_en` = 0, `out_empty` = 1, `busy` = 0, `out` = 0.
  - Data in flight is discarded.
  - Reset mid-transfer pops nothing in the reset cycle.

## Timing
- Pair issued in cycle t: registered in S1 at the edge ending t, S2 at t+1, S3 at t+2. FIFO write occurs at the edge ending t+3. `out_empty` falls at t+4 when the FIFO was empty.
- Throughput: one pair per cycle while the sources are non-empty and credits remain.
- Full boundary: with the output never popped, exactly `FIFO_DEPTH` pairs are issued, after which the rd_en strobes stay low.
- Pop and issue in the same cycle: the credit freed by a pop in cycle t is usable for issue in cycle t+1.
- Both sources must be non-empty. One empty source blocks issue without popping the other.

## Structure
- Shared package `functs` holds:
  - `mul_frac_round_sat`, parameterised through a wrapping class or explicit widths, returning the result and an overflow bit.
  - Default constants `FRAC_BITS_Q10` = 10 and `DATA_WIDTH_32` = 32.
- One sub-module: the existing `fifo` (`FIFO_BUFFER_SIZE` = `FIFO_DEPTH`, `FIFO_DATA_WIDTH` = `DATA_WIDTH`), with `wr_clk` and `rd_clk` both tied to `clock`.
- Credit and occupancy counters are local, `$clog2(FIFO_DEPTH)+1` bits wide.

## Test plan
All cases use W = 32, F = 10 unless stated.
- 2048 × 1536, truncate → 3072. Back-to-back 8 pairs → rd_en high 8 consecutive cycles, 8 outputs in order.
- 1 × 512 → truncate 0, round 1. −1 × 512 → truncate −1 (0xFFFFFFFF), round 0.
- 0x7FFFFFFF × 2048:
  - with `sat_en` = 1 → 0x7FFFFFFF, `overflow` = 1.
  - with `sat_en` = 0 → 0xFFFFFFFE, `overflow` = 1.
  - `clear_ovf` → 0 the next cycle.
- `FIFO_DEPTH` = 4, no `out_rd_en`, 10 pairs offered:
  - exactly 4 pops, then rd_en held low.
  - drain one → exactly one further pop.
  - no loss or duplication over all 10.
- `ina` empty, `inb` non-empty for 20 cycles → no `inb_rd_en`. `ina` fills → pairs matched in order.
- Reset asserted 1 cycle after issuing 3 pairs → `out_empty` = 1 and `busy` = 0 after reset, no stray write. The following pair is the first output.
